// File: rtl/magic_readback_pkg.sv
// Shared definitions for the magic-mode configuration port: port address,
// register indices (common to read and write sides) and configuration types.
package common;

    localparam logic [7:0] MAGIC_PORT_LO       = 8'hFF;

    localparam logic [7:0] MAGIC_REG_REBOOT    = 8'h00;
    localparam logic [7:0] MAGIC_REG_BEEPER    = 8'h01;
    localparam logic [7:0] MAGIC_REG_TIMINGS   = 8'h02;
    localparam logic [7:0] MAGIC_REG_TURBO     = 8'h03;
    localparam logic [7:0] MAGIC_REG_AY        = 8'h04;
    localparam logic [7:0] MAGIC_REG_ROM_PLUS3 = 8'h05;
    localparam logic [7:0] MAGIC_REG_ROM_ALT48 = 8'h06;
    localparam logic [7:0] MAGIC_REG_JOY       = 8'h07;
    localparam logic [7:0] MAGIC_REG_RAM_MODE  = 8'h08;
    localparam logic [7:0] MAGIC_REG_DIVMMC    = 8'h09;
    localparam logic [7:0] MAGIC_REG_ULAPLUS   = 8'h0A;
    localparam logic [7:0] MAGIC_REG_SD_COVOX  = 8'h0B;
    localparam logic [7:0] MAGIC_REG_STATUS    = 8'h80;
    localparam logic [7:0] MAGIC_REG_FCNT_LO   = 8'h81;
    localparam logic [7:0] MAGIC_REG_FCNT_HI   = 8'h82;

    typedef enum logic [1:0] {
        TIMINGS_48   = 2'd0,
        TIMINGS_128  = 2'd1,
        TIMINGS_PENT = 2'd2,
        TIMINGS_P3   = 2'd3
    } timings_t;

    typedef enum logic [1:0] {
        TURBO_NONE = 2'd0,
        TURBO_X2   = 2'd1,
        TURBO_X4   = 2'd2,
        TURBO_X8   = 2'd3
    } turbo_t;

    typedef enum logic [1:0] {
        RAMMODE_48   = 2'd0,
        RAMMODE_128  = 2'd1,
        RAMMODE_P3   = 2'd2,
        RAMMODE_PENT = 2'd3
    } rammode_t;

endpackage

// File: rtl/magic_readback_if.sv
// CPU bus signals seen by the I/O responders. Handshake: a read cycle is in
// progress while ioreq and rd are both high; a[15:0] is stable for its duration.
interface cpu_bus;
    logic [15:0] a;
    logic        ioreq;
    logic        rd;

    modport master (output a, ioreq, rd);
    modport slave  (input  a, ioreq, rd);
endinterface

// File: rtl/magic_readback_sync_edge.sv
// Two-flop synchronizer with a one-clock pulse marking the synchronized level's
// rising edge; the pulse is aligned so a consumer flop sets on the same edge q rises.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q    = s2_q;
    assign rise = s1_q & ~s2_q;
endmodule

// File: rtl/magic_readback.sv
// Read side of the magic configuration port (IN xxFF while the magic ROM is mapped).
// Optional 16-bit frame counter at indices 81/82 is built when MAGIC_FRAMECNT_EN is defined.
module magic_readback
    import common::*;
(
    input  logic       clk28,
    input  logic       rst_n,
    cpu_bus.slave      bus,
    input  logic       n_int,
    input  logic       magic_button,
    input  logic       magic_map,
    input  logic       magic_reboot,
    input  logic       magic_beeper,
    input  logic       rom_plus3,
    input  logic       rom_alt48,
    input  logic       joy_sinclair,
    input  logic       divmmc_en,
    input  logic       ulaplus_en,
    input  logic       covox_en,
    input  logic       sd_en,
    input  logic       ay_abc,
    input  logic       ay_mono,
    input  timings_t   timings,
    input  turbo_t     turbo,
    input  rammode_t   ram_mode,
    output logic [7:0] d_out,
    output logic       d_out_active
);
    logic       cs, read_start, read_end;
    logic       cs_q, cs_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] d_out_q, d_out_d;
    logic       active_q, active_d;
    logic       btn_event_q, btn_event_d;
    logic       btn_sync, btn_rise;
    logic [7:0] rd_data;

    sync_edge u_btn_sync (
        .clk   (clk28),
        .rst_n (rst_n),
        .d     (magic_button),
        .q     (btn_sync),
        .rise  (btn_rise)
    );

    assign cs         = magic_map && bus.ioreq && bus.rd && (bus.a[7:0] == MAGIC_PORT_LO);
    assign read_start = cs & ~cs_q;
    assign read_end   = ~cs & cs_q;

`ifdef MAGIC_FRAMECNT_EN
    logic        nint_q, nint_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [7:0]  fcnt_hi_shadow_q, fcnt_hi_shadow_d;

    // Shadow captures from the pre-increment count, matching the low byte
    // returned by the same read even when a frame edge lands on that clock.
    always_comb begin
        nint_d           = n_int;
        fcnt_d           = fcnt_q + 16'(nint_q & ~n_int);
        fcnt_hi_shadow_d = fcnt_hi_shadow_q;
        if (read_start && (bus.a[15:8] == MAGIC_REG_FCNT_LO))
            fcnt_hi_shadow_d = fcnt_q[15:8];
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            nint_q           <= 1'b1;
            fcnt_q           <= 16'h0000;
            fcnt_hi_shadow_q <= 8'h00;
        end else begin
            nint_q           <= nint_d;
            fcnt_q           <= fcnt_d;
            fcnt_hi_shadow_q <= fcnt_hi_shadow_d;
        end
    end
`else
    logic unused_n_int;
    assign unused_n_int = n_int;
`endif

    always_comb begin
        rd_data = 8'hFF;
        case (bus.a[15:8])
            MAGIC_REG_REBOOT:    rd_data = {7'b0, magic_reboot};
            MAGIC_REG_BEEPER:    rd_data = {7'b0, magic_beeper};
            MAGIC_REG_TIMINGS:   rd_data = {6'b0, timings};
            MAGIC_REG_TURBO:     rd_data = {6'b0, turbo};
            MAGIC_REG_AY:        rd_data = {6'b0, ay_mono, ~ay_abc};
            MAGIC_REG_ROM_PLUS3: rd_data = {7'b0, rom_plus3};
            MAGIC_REG_ROM_ALT48: rd_data = {7'b0, rom_alt48};
            MAGIC_REG_JOY:       rd_data = {7'b0, joy_sinclair};
            MAGIC_REG_RAM_MODE:  rd_data = {6'b0, ram_mode};
            MAGIC_REG_DIVMMC:    rd_data = {7'b0, divmmc_en};
            MAGIC_REG_ULAPLUS:   rd_data = {7'b0, ulaplus_en};
            MAGIC_REG_SD_COVOX:  rd_data = {6'b0, sd_en, covox_en};
            MAGIC_REG_STATUS:    rd_data = {6'b0, btn_event_q, btn_sync};
`ifdef MAGIC_FRAMECNT_EN
            MAGIC_REG_FCNT_LO:   rd_data = fcnt_q[7:0];
            MAGIC_REG_FCNT_HI:   rd_data = fcnt_hi_shadow_q;
`endif
            default:             rd_data = 8'hFF;
        endcase
    end

    // Data is frozen at read start; the sticky event clears only at read end so a
    // sub-clock glitch on cs cannot swallow it, and a coincident new edge wins.
    always_comb begin
        cs_d     = cs;
        idx_d    = idx_q;
        d_out_d  = d_out_q;
        active_d = active_q;
        if (read_start) begin
            idx_d    = bus.a[15:8];
            d_out_d  = rd_data;
            active_d = 1'b1;
        end else if (read_end) begin
            d_out_d  = 8'hFF;
            active_d = 1'b0;
        end
        btn_event_d = btn_rise |
                      (btn_event_q & ~(read_end && (idx_q == MAGIC_REG_STATUS)));
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cs_q        <= 1'b0;
            idx_q       <= 8'h00;
            d_out_q     <= 8'hFF;
            active_q    <= 1'b0;
            btn_event_q <= 1'b0;
        end else begin
            cs_q        <= cs_d;
            idx_q       <= idx_d;
            d_out_q     <= d_out_d;
            active_q    <= active_d;
            btn_event_q <= btn_event_d;
        end
    end

    assign d_out        = d_out_q;
    assign d_out_active = active_q;
endmodule
